// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for a single-port sync RAM (IDLE->ISSUE->RESP).
// Optional macro DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed processor priority.
module dmem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int SAT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        i_cpu_func,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_ready,
   input  logic              i_aux_req,
   input  logic              i_aux_we,
   input  logic [ADDR_W-1:0] i_aux_addr,
   input  logic [DATA_W-1:0] i_aux_wdata,
   output logic [DATA_W-1:0] o_aux_rdata,
   output logic              o_aux_ack,
   output logic              o_ram_en,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_busy,
   output logic              o_last_grant,
   output logic [SAT_W-1:0]  o_cpu_cnt,
   output logic [SAT_W-1:0]  o_aux_cnt
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t            r_state, w_next;
   logic              r_owner, r_we, r_last_grant, r_cpu_ready, r_aux_ack;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_cpu_rdata, r_aux_rdata;
   logic [SAT_W-1:0]  r_cpu_cnt, r_aux_cnt;
   logic              w_cpu_pend, w_aux_pend, w_grant, w_win_aux;
   assign w_cpu_pend = (i_cpu_func == 2'b01) || (i_cpu_func == 2'b10);
   assign w_aux_pend = i_aux_req;
   assign w_grant    = w_cpu_pend || w_aux_pend;
`ifdef DMEM_ARB_RR_EN
   // r_any keeps the very first conflict after reset with the processor
   logic r_any;
   assign w_win_aux = w_aux_pend && (!w_cpu_pend || (r_any && !r_last_grant));
`else
   assign w_win_aux = w_aux_pend && !w_cpu_pend;
`endif
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE)  ? (w_grant ? ISSUE : IDLE) :
               (r_state == ISSUE) ? RESP : IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_owner      <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_last_grant <= 1'b0;
         r_cpu_ready  <= 1'b0;
         r_aux_ack    <= 1'b0;
         r_cpu_rdata  <= '0;
         r_aux_rdata  <= '0;
         r_cpu_cnt    <= '0;
         r_aux_cnt    <= '0;
`ifdef DMEM_ARB_RR_EN
         r_any        <= 1'b0;
`endif
      end else begin
         r_state     <= w_next;
         r_cpu_ready <= 1'b0;
         r_aux_ack   <= 1'b0;
         if (r_state == IDLE && w_grant) begin
            r_owner      <= w_win_aux;
            r_we         <= w_win_aux ? i_aux_we : (i_cpu_func == 2'b10);
            r_addr       <= w_win_aux ? i_aux_addr : i_cpu_addr;
            r_wdata      <= w_win_aux ? i_aux_wdata : i_cpu_wdata;
            r_last_grant <= w_win_aux;
`ifdef DMEM_ARB_RR_EN
            r_any        <= 1'b1;
`endif
         end
         if (r_state == RESP) begin
            if (r_owner) begin
               r_aux_ack <= 1'b1;
               r_aux_cnt <= r_aux_cnt + SAT_W'(r_aux_cnt != '1);
               if (!r_we) r_aux_rdata <= i_ram_rdata;
            end else begin
               r_cpu_ready <= 1'b1;
               r_cpu_cnt   <= r_cpu_cnt + SAT_W'(r_cpu_cnt != '1);
               if (!r_we) r_cpu_rdata <= i_ram_rdata;
            end
         end
      end
   end
   // latched address/data only change on a grant, so the RAM port holds them while idle
   assign o_ram_en     = (r_state == ISSUE);
   assign o_ram_we     = (r_state == ISSUE) && r_we;
   assign o_ram_addr   = r_addr;
   assign o_ram_wdata  = r_wdata;
   assign o_busy       = (r_state != IDLE);
   assign o_last_grant = r_last_grant;
   assign o_cpu_ready  = r_cpu_ready;
   assign o_aux_ack    = r_aux_ack;
   assign o_cpu_rdata  = r_cpu_rdata;
   assign o_aux_rdata  = r_aux_rdata;
   assign o_cpu_cnt    = r_cpu_cnt;
   assign o_aux_cnt    = r_aux_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural 256x8 sync RAM.
module tb_dmem_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] i_cpu_func = 2'b00;
   logic [7:0] i_cpu_addr = '0, i_cpu_wdata = '0;
   logic       i_aux_req = 1'b0, i_aux_we = 1'b0;
   logic [7:0] i_aux_addr = '0, i_aux_wdata = '0;
   logic [7:0] i_ram_rdata = '0;
   logic [7:0] o_cpu_rdata, o_aux_rdata, o_ram_addr, o_ram_wdata, o_cpu_cnt, o_aux_cnt;
   logic       o_cpu_ready, o_aux_ack, o_ram_en, o_ram_we, o_busy, o_last_grant;
   logic [7:0] mem [256];
   int         n_pass = 0, n_total = 0;

   dmem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_cpu_func(i_cpu_func), .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
      .o_cpu_rdata(o_cpu_rdata), .o_cpu_ready(o_cpu_ready),
      .i_aux_req(i_aux_req), .i_aux_we(i_aux_we), .i_aux_addr(i_aux_addr), .i_aux_wdata(i_aux_wdata),
      .o_aux_rdata(o_aux_rdata), .o_aux_ack(o_aux_ack),
      .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
      .i_ram_rdata(i_ram_rdata), .o_busy(o_busy), .o_last_grant(o_last_grant),
      .o_cpu_cnt(o_cpu_cnt), .o_aux_cnt(o_aux_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (o_ram_en) begin
         if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
         else i_ram_rdata <= mem[o_ram_addr];
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [53:0] all_outs();
      return {o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_busy, o_last_grant,
              o_cpu_ready, o_aux_ack, o_cpu_rdata, o_aux_rdata, o_cpu_cnt, o_aux_cnt};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_total++; if (all_outs() !== 54'd0) $display("FAIL reset_outputs got=%h want=0", all_outs()); else n_pass++;
      rst_n = 1'b1;
      tick();
      n_total++; if (o_busy !== 1'b0) $display("FAIL reset_idle busy=%b want=0", o_busy); else n_pass++;
   endtask

   task automatic test_cpu_write();
      i_cpu_func = 2'b10; i_cpu_addr = 8'h12; i_cpu_wdata = 8'hA5;
      tick();
      n_total++; if ({o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_busy} !== {1'b1, 1'b1, 8'h12, 8'hA5, 1'b1})
         $display("FAIL wr_issue got en=%b we=%b a=%h d=%h busy=%b want 1 1 12 a5 1", o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_busy);
      else n_pass++;
      i_cpu_func = 2'b00;
      tick();
      n_total++; if ({o_ram_en, o_ram_we, o_cpu_ready, o_busy} !== 4'b0001)
         $display("FAIL wr_resp got en=%b we=%b rdy=%b busy=%b want 0 0 0 1", o_ram_en, o_ram_we, o_cpu_ready, o_busy);
      else n_pass++;
      tick();
      n_total++; if ({o_cpu_ready, o_busy, o_cpu_cnt, o_ram_addr} !== {1'b1, 1'b0, 8'd1, 8'h12})
         $display("FAIL wr_done got rdy=%b busy=%b cnt=%0d addr=%h want 1 0 1 12", o_cpu_ready, o_busy, o_cpu_cnt, o_ram_addr);
      else n_pass++;
      tick();
      n_total++; if (o_cpu_ready !== 1'b0) $display("FAIL wr_pulse_width rdy=%b want=0", o_cpu_ready); else n_pass++;
   endtask

   task automatic test_cpu_read();
      i_cpu_func = 2'b01; i_cpu_addr = 8'h12;
      tick();
      n_total++; if ({o_ram_en, o_ram_we} !== 2'b10) $display("FAIL rd_issue en=%b we=%b want 1 0", o_ram_en, o_ram_we); else n_pass++;
      i_cpu_func = 2'b00;
      tick();
      tick();
      n_total++; if ({o_cpu_ready, o_cpu_rdata, o_aux_rdata, o_cpu_cnt} !== {1'b1, 8'hA5, 8'h00, 8'd2})
         $display("FAIL rd_done got rdy=%b rdata=%h aux_rdata=%h cnt=%0d want 1 a5 00 2", o_cpu_ready, o_cpu_rdata, o_aux_rdata, o_cpu_cnt);
      else n_pass++;
      tick();
   endtask

   task automatic test_aux();
      i_aux_req = 1'b1; i_aux_we = 1'b1; i_aux_addr = 8'hFF; i_aux_wdata = 8'h3C;
      tick();
      n_total++; if ({o_ram_we, o_ram_addr, o_last_grant, o_busy} !== {1'b1, 8'hFF, 1'b1, 1'b1})
         $display("FAIL aux_wr_issue got we=%b a=%h lg=%b busy=%b want 1 ff 1 1", o_ram_we, o_ram_addr, o_last_grant, o_busy);
      else n_pass++;
      tick();
      tick();
      n_total++; if ({o_aux_ack, o_busy} !== 2'b10) $display("FAIL aux_wr_done ack=%b busy=%b want 1 0", o_aux_ack, o_busy); else n_pass++;
      i_aux_we = 1'b0;
      tick();
      n_total++; if ({o_busy, o_ram_en, o_ram_we, o_aux_ack} !== 4'b1100)
         $display("FAIL aux_rd_issue busy=%b en=%b we=%b ack=%b want 1 1 0 0", o_busy, o_ram_en, o_ram_we, o_aux_ack);
      else n_pass++;
      tick();
      tick();
      n_total++; if ({o_aux_ack, o_aux_rdata, o_aux_cnt, o_cpu_rdata} !== {1'b1, 8'h3C, 8'd2, 8'hA5})
         $display("FAIL aux_rd_done ack=%b rdata=%h cnt=%0d cpu_rdata=%h want 1 3c 2 a5", o_aux_ack, o_aux_rdata, o_aux_cnt, o_cpu_rdata);
      else n_pass++;
      i_aux_req = 1'b0;
      tick();
      n_total++; if (o_busy !== 1'b0) $display("FAIL aux_release busy=%b want 0", o_busy); else n_pass++;
   endtask

   task automatic test_conflict();
      logic [7:0] exp_addr [3];
      logic       exp_lg [3];
`ifdef DMEM_ARB_RR_EN
      exp_addr = '{8'h01, 8'h02, 8'h01};
      exp_lg   = '{1'b0, 1'b1, 1'b0};
`else
      exp_addr = '{8'h01, 8'h01, 8'h01};
      exp_lg   = '{1'b0, 1'b0, 1'b0};
`endif
      i_cpu_func = 2'b01; i_cpu_addr = 8'h01;
      i_aux_req = 1'b1; i_aux_we = 1'b0; i_aux_addr = 8'h02;
      for (int g = 0; g < 3; g++) begin
         tick();
         n_total++; if ({o_ram_addr, o_last_grant} !== {exp_addr[g], exp_lg[g]})
            $display("FAIL conflict_grant%0d addr=%h lg=%b want %h %b", g, o_ram_addr, o_last_grant, exp_addr[g], exp_lg[g]);
         else n_pass++;
         tick();
         tick();
         n_total++; if ({o_cpu_ready, o_aux_ack} !== {~exp_lg[g], exp_lg[g]})
            $display("FAIL conflict_strobe%0d rdy=%b ack=%b want %b %b", g, o_cpu_ready, o_aux_ack, ~exp_lg[g], exp_lg[g]);
         else n_pass++;
         if (g == 2) begin
            i_cpu_func = 2'b00; i_aux_req = 1'b0;
         end
      end
      tick();
`ifdef DMEM_ARB_RR_EN
      n_total++; if ({o_cpu_cnt, o_aux_cnt, o_cpu_rdata, o_aux_rdata} !== {8'd4, 8'd3, 8'h5B, 8'h58})
`else
      n_total++; if ({o_cpu_cnt, o_aux_cnt, o_cpu_rdata, o_aux_rdata} !== {8'd5, 8'd2, 8'h5B, 8'h3C})
`endif
         $display("FAIL conflict_counts cpu_cnt=%0d aux_cnt=%0d cpu_rdata=%h aux_rdata=%h", o_cpu_cnt, o_aux_cnt, o_cpu_rdata, o_aux_rdata);
      else n_pass++;
   endtask

   task automatic test_reserved_and_saturate();
      logic [7:0] cnt0;
      int         pulses = 0;
      cnt0 = o_cpu_cnt;
      i_cpu_func = 2'b11; i_cpu_addr = 8'h01;
      for (int c = 0; c < 10; c++) begin
         tick();
         n_total++; if ({o_ram_en, o_busy} !== 2'b00) $display("FAIL reserved_cyc%0d en=%b busy=%b want 0 0", c, o_ram_en, o_busy); else n_pass++;
      end
      n_total++; if (o_cpu_cnt !== cnt0) $display("FAIL reserved_cnt got=%0d want=%0d", o_cpu_cnt, cnt0); else n_pass++;
      i_cpu_func = 2'b01;
      for (int c = 0; c < 1000 && pulses < 260; c++) begin
         tick();
         if (o_cpu_ready) pulses++;
      end
      i_cpu_func = 2'b00;
      n_total++; if (pulses !== 260) $display("FAIL sat_pulses got=%0d want=260", pulses); else n_pass++;
      n_total++; if (o_cpu_cnt !== 8'hFF) $display("FAIL sat_cnt got=%h want=ff", o_cpu_cnt); else n_pass++;
      tick();
      n_total++; if ({o_busy, o_cpu_cnt} !== {1'b0, 8'hFF}) $display("FAIL sat_hold busy=%b cnt=%h want 0 ff", o_busy, o_cpu_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid();
      i_aux_req = 1'b1; i_aux_we = 1'b0; i_aux_addr = 8'h02;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      n_total++; if (o_aux_ack !== 1'b0) $display("FAIL abort_no_ack ack=%b want 0", o_aux_ack); else n_pass++;
      n_total++; if (all_outs() !== 54'd0) $display("FAIL abort_outputs got=%h want=0", all_outs()); else n_pass++;
      rst_n = 1'b1; i_aux_req = 1'b0;
      tick();
      i_aux_req = 1'b1; i_aux_we = 1'b1; i_aux_addr = 8'h40; i_aux_wdata = 8'h77;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      n_total++; if (o_aux_ack !== 1'b0) $display("FAIL abort_wr_no_ack ack=%b want 0", o_aux_ack); else n_pass++;
      rst_n = 1'b1; i_aux_req = 1'b0;
      tick();
      i_cpu_func = 2'b01; i_cpu_addr = 8'h40;
      tick();
      i_cpu_func = 2'b00;
      tick();
      tick();
      n_total++; if ({o_cpu_ready, o_cpu_rdata, o_cpu_cnt} !== {1'b1, 8'h77, 8'd1})
         $display("FAIL abort_wr_kept rdy=%b rdata=%h cnt=%0d want 1 77 1", o_cpu_ready, o_cpu_rdata, o_cpu_cnt);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_aux();
      test_conflict();
      test_reserved_and_saturate();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 256x8 data memory.
- Requester 0 is the processor data port, using the 2-bit memory-function encoding: 00 idle, 01 read, 10 write, 11 reserved.
- Requester 1 is an auxiliary loader/debug port with a req/ack handshake.
- The block serialises both requesters onto one synchronous RAM port with 1-cycle read latency, returns read data and generates completion strobes.

Parameters:
ADDR_W, 8, address width of both requesters and the RAM port
DATA_W, 8, data width
SAT_W, 8, width of the saturating per-requester grant counters

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
cpu_func  input  2  processor memory function: 00 idle, 01 read, 10 write, 11 reserved (treated as idle)
cpu_addr  input  ADDR_W  processor read/write address
cpu_wdata  input  DATA_W  processor write data
cpu_rdata  output  DATA_W  registered read data returned to the processor
cpu_ready  output  1  one-cycle completion strobe for the processor access
aux_req  input  1  auxiliary request, level, held until aux_ack
aux_we  input  1  1 = write, 0 = read
aux_addr  input  ADDR_W  auxiliary address
aux_wdata  input  DATA_W  auxiliary write data
aux_rdata  output  DATA_W  registered read data returned to the auxiliary port
aux_ack  output  1  one-cycle completion strobe for the auxiliary access
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_en=1 with ram_we=0
busy  output  1  1 while the FSM is not in IDLE
last_grant  output  1  0 = processor, 1 = auxiliary; owner of the most recent grant
cpu_cnt  output  SAT_W  saturating count of completed processor accesses
aux_cnt  output  SAT_W  saturating count of completed auxiliary accesses

Behaviour:
- Reset values (rst_n=0 at a posedge): all outputs 0, FSM in IDLE, latched request info cleared.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - A processor request is pending when cpu_func is 01 or 10.
  - An auxiliary request is pending when aux_req=1.
  - If none is pending, stay in IDLE.
  - Otherwise select a winner, latch its owner/we/addr/wdata, set last_grant, go to ISSUE.
- ISSUE (one cycle):
  - Drive ram_en=1, ram_we=latched we, ram_addr and ram_wdata from the latched values. A write commits on this cycle's edge.
  - Go to RESP.
- RESP (one cycle):
  - For a read, capture ram_rdata into the owner's rdata register.
  - Pulse the owner's ready/ack for exactly one cycle (visible the cycle after RESP's edge).
  - Increment the owner's counter, saturating at all-ones.
  - Return to IDLE.
- Timing and ports when idle:
  - Latency from request seen in IDLE to strobe high: 3 cycles.
  - Sustained throughput: one access per 3 cycles.
  - ram_en=0 and ram_we=0 in every state other than ISSUE.
  - ram_addr and ram_wdata hold their last values when ram_en=0.
- rdata persistence: cpu_rdata and aux_rdata hold their value until the next read completed by the same owner. Writes never modify them.
- Requester inputs are sampled only in IDLE. Changes while busy are ignored. A request still asserted after its strobe is treated as a new access.
- Default arbitration is fixed priority: the processor wins on simultaneous requests.
- cpu_func=11 is never granted and never counted.
- Reset mid-operation aborts the transaction with no strobe. A write whose ISSUE edge already occurred stays committed in the RAM.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- When defined, arbitration is round-robin: on a simultaneous request the requester that did not own last_grant wins. The first conflict after reset goes to the processor (last_grant resets to 0, so the processor is treated as "last" only after its first grant; the tie-break for the first conflict is the processor).
- When undefined, arbitration is fixed priority with the processor always winning. The auxiliary port can starve under continuous processor traffic.

Test Plan:
- Reset, then processor write: cpu_func=10, addr=0x12, wdata=0xA5 -> ram_en=ram_we=1, ram_addr=0x12 on the ISSUE cycle; cpu_ready pulses 1 cycle; cpu_cnt=1.
- Processor read of 0x12 after that write -> cpu_rdata=0xA5 when cpu_ready pulses, 3 cycles after the request; aux_rdata unchanged at 0.
- Auxiliary write 0x3C to addr 0xFF, then aux read of 0xFF -> two aux_ack pulses; aux_rdata=0x3C; aux_cnt=2; busy is low only between the two accesses.
- Simultaneous processor read 0x01 and aux read 0x02, both held:
  - fixed priority: three consecutive processor grants with aux waiting;
  - DMEM_ARB_RR_EN: grants alternate cpu, aux, cpu; last_grant toggles 0, 1, 0.
- cpu_func=11 held for 10 cycles -> no ram_en, busy=0, cpu_cnt unchanged. Then 260 back-to-back processor reads -> cpu_cnt saturates at 0xFF.
- rst_n=0 asserted during RESP of an aux read -> no aux_ack, all outputs 0 next cycle. A write asserted the same way after its ISSUE cycle reads back its data after reset.
